// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, byte-enabled doubleword data memory,
// load extraction and MEM/WB register of the five-stage core.
module mem_stage #(
    parameter int BUS_WIDTH    = 64,
    parameter int REGFILE_LEN  = 6,
    parameter int DATA_MEM_LEN = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_reg_write,
    input  logic                   in_mem_write,
    input  logic                   in_mem_read,
    input  logic                   in_mem_to_reg,
    input  logic [2:0]             in_funct3,
    input  logic [BUS_WIDTH-1:0]   in_alu_fpu_result,
    input  logic [BUS_WIDTH-1:0]   in_read_data2,
    input  logic [REGFILE_LEN-1:0] in_rd,
    output logic                   mem_fwd_reg_write,
    output logic [REGFILE_LEN-1:0] mem_fwd_rd,
    output logic [BUS_WIDTH-1:0]   mem_fwd_data,
    output logic [BUS_WIDTH-1:0]   mem_out,
    output logic                   wb_reg_write,
    output logic [REGFILE_LEN-1:0] wb_rd,
    output logic [BUS_WIDTH-1:0]   wb_write_data,
    output logic                   misalign
);
    localparam int MEM_WORDS = 1 << DATA_MEM_LEN;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    // EX/MEM register
    logic                   exm_reg_write_q, exm_reg_write_d;
    logic                   exm_mem_write_q, exm_mem_write_d;
    logic                   exm_mem_read_q, exm_mem_read_d;
    logic                   exm_mem_to_reg_q, exm_mem_to_reg_d;
    logic [2:0]             exm_funct3_q, exm_funct3_d;
    logic [BUS_WIDTH-1:0]   exm_result_q, exm_result_d;
    logic [BUS_WIDTH-1:0]   exm_store_q, exm_store_d;
    logic [REGFILE_LEN-1:0] exm_rd_q, exm_rd_d;

    // MEM/WB register and registered read data
    logic                   wb_reg_write_q, wb_reg_write_d;
    logic                   wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REGFILE_LEN-1:0] wb_rd_q, wb_rd_d;
    logic [BUS_WIDTH-1:0]   wb_result_q, wb_result_d;
    logic [2:0]             wb_funct3_q, wb_funct3_d;
    logic [2:0]             wb_off_q, wb_off_d;
    logic                   wb_mis_q, wb_mis_d;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;

    logic [BUS_WIDTH-1:0]    dmem [MEM_WORDS];
    logic [DATA_MEM_LEN-1:0] mem_idx;
    logic [2:0]              exm_off;
    size_e                   exm_size;
    logic                    exm_aligned;
    logic                    exm_mis;
    logic [7:0]              size_mask;
    logic [7:0]              mem_be;
    logic [BUS_WIDTH-1:0]    mem_wdata;
    logic                    mem_we;
    logic [BUS_WIDTH-1:0]    shifted;
    logic [BUS_WIDTH-1:0]    ext;

    always_comb begin
        exm_reg_write_d  = exm_reg_write_q;
        exm_mem_write_d  = exm_mem_write_q;
        exm_mem_read_d   = exm_mem_read_q;
        exm_mem_to_reg_d = exm_mem_to_reg_q;
        exm_funct3_d     = exm_funct3_q;
        exm_result_d     = exm_result_q;
        exm_store_d      = exm_store_q;
        exm_rd_d         = exm_rd_q;
        if (flush || !stall) begin
            exm_funct3_d = in_funct3;
            exm_result_d = in_alu_fpu_result;
            exm_store_d  = in_read_data2;
            exm_rd_d     = in_rd;
        end
        // a flush wins over stall so the bubble enters even while held
        if (flush) begin
            exm_reg_write_d  = 1'b0;
            exm_mem_write_d  = 1'b0;
            exm_mem_read_d   = 1'b0;
            exm_mem_to_reg_d = 1'b0;
        end else if (!stall) begin
            exm_reg_write_d  = in_reg_write;
            exm_mem_write_d  = in_mem_write;
            exm_mem_read_d   = in_mem_read;
            exm_mem_to_reg_d = in_mem_to_reg;
        end
    end

    always_comb begin
        exm_off     = exm_result_q[2:0];
        exm_size    = size_e'(exm_funct3_q[1:0]);
        exm_aligned = 1'b1;
        size_mask   = 8'h01;
        unique case (exm_size)
            SZ_B: begin
                exm_aligned = 1'b1;
                size_mask   = 8'h01;
            end
            SZ_H: begin
                exm_aligned = ~exm_off[0];
                size_mask   = 8'h03;
            end
            SZ_W: begin
                exm_aligned = (exm_off[1:0] == 2'b00);
                size_mask   = 8'h0F;
            end
            SZ_D: begin
                exm_aligned = (exm_off == 3'b000);
                size_mask   = 8'hFF;
            end
        endcase
        exm_mis   = (exm_mem_read_q | exm_mem_write_q) & ~exm_aligned;
        mem_idx   = exm_result_q[DATA_MEM_LEN+2:3];
        mem_be    = size_mask << exm_off;
        mem_wdata = exm_store_q << {exm_off, 3'b000};
        mem_we    = exm_mem_write_q & ~exm_mis & ~stall;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_be[b]) begin
                    dmem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_result_d     = wb_result_q;
        wb_funct3_d     = wb_funct3_q;
        wb_off_d        = wb_off_q;
        wb_mis_d        = wb_mis_q;
        rdata_d         = rdata_q;
        if (!stall) begin
            wb_reg_write_d  = exm_reg_write_q & (exm_rd_q != '0) & ~exm_mis;
            wb_mem_to_reg_d = exm_mem_to_reg_q;
            wb_rd_d         = exm_rd_q;
            wb_result_d     = exm_result_q;
            wb_funct3_d     = exm_funct3_q;
            wb_off_d        = exm_off;
            wb_mis_d        = exm_mis;
            rdata_d         = dmem[mem_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_reg_write_q  <= 1'b0;
            exm_mem_write_q  <= 1'b0;
            exm_mem_read_q   <= 1'b0;
            exm_mem_to_reg_q <= 1'b0;
            exm_funct3_q     <= '0;
            exm_result_q     <= '0;
            exm_store_q      <= '0;
            exm_rd_q         <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_rd_q          <= '0;
            wb_result_q      <= '0;
            wb_funct3_q      <= '0;
            wb_off_q         <= '0;
            wb_mis_q         <= 1'b0;
            rdata_q          <= '0;
        end else begin
            exm_reg_write_q  <= exm_reg_write_d;
            exm_mem_write_q  <= exm_mem_write_d;
            exm_mem_read_q   <= exm_mem_read_d;
            exm_mem_to_reg_q <= exm_mem_to_reg_d;
            exm_funct3_q     <= exm_funct3_d;
            exm_result_q     <= exm_result_d;
            exm_store_q      <= exm_store_d;
            exm_rd_q         <= exm_rd_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_rd_q          <= wb_rd_d;
            wb_result_q      <= wb_result_d;
            wb_funct3_q      <= wb_funct3_d;
            wb_off_q         <= wb_off_d;
            wb_mis_q         <= wb_mis_d;
            rdata_q          <= rdata_d;
        end
    end

    always_comb begin
        shifted = rdata_q >> {wb_off_q, 3'b000};
        unique case (wb_funct3_q)
            3'b000:  ext = {{(BUS_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{(BUS_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ext = {{(BUS_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ext = {{(BUS_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  ext = {{(BUS_WIDTH-16){1'b0}}, shifted[15:0]};
            3'b110:  ext = {{(BUS_WIDTH-32){1'b0}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    assign mem_out           = wb_mis_q ? '0 : ext;
    assign wb_reg_write      = wb_reg_write_q;
    assign wb_rd             = wb_rd_q;
    assign wb_write_data     = wb_mem_to_reg_q ? mem_out : wb_result_q;
    assign misalign          = wb_mis_q;
    assign mem_fwd_reg_write = exm_reg_write_q & (exm_rd_q != '0);
    assign mem_fwd_rd        = exm_rd_q;
    assign mem_fwd_data      = exm_result_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against
// a byte-addressed memory model and an in-order expectation queue.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_reg_write;
    logic        in_mem_write;
    logic        in_mem_read;
    logic        in_mem_to_reg;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_fpu_result;
    logic [63:0] in_read_data2;
    logic [5:0]  in_rd;
    logic        mem_fwd_reg_write;
    logic [5:0]  mem_fwd_rd;
    logic [63:0] mem_fwd_data;
    logic [63:0] mem_out;
    logic        wb_reg_write;
    logic [5:0]  wb_rd;
    logic [63:0] wb_write_data;
    logic        misalign;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .in_reg_write      (in_reg_write),
        .in_mem_write      (in_mem_write),
        .in_mem_read       (in_mem_read),
        .in_mem_to_reg     (in_mem_to_reg),
        .in_funct3         (in_funct3),
        .in_alu_fpu_result (in_alu_fpu_result),
        .in_read_data2     (in_read_data2),
        .in_rd             (in_rd),
        .mem_fwd_reg_write (mem_fwd_reg_write),
        .mem_fwd_rd        (mem_fwd_rd),
        .mem_fwd_data      (mem_fwd_data),
        .mem_out           (mem_out),
        .wb_reg_write      (wb_reg_write),
        .wb_rd             (wb_rd),
        .wb_write_data     (wb_write_data),
        .misalign          (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          care;
        bit          is_ld;
        bit          rw;
        bit          fwd_rw;
        bit          mis;
        logic [5:0]  rd;
        logic [63:0] res;
        logic [63:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_b [0:32767];
    exp_t        q[$];
    exp_t        last_wb;
    exp_t        bubble;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 4;
            default:        return 8;
        endcase
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a,
                                               input logic [2:0] f3);
        logic [63:0] v;
        int n;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = mem_b[15'(a[14:0] + 15'(i))];
        if (n < 8 && !f3[2] && v[8*n-1])
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [63:0] sd,
                               input int n);
        for (int i = 0; i < n; i++)
            mem_b[15'(a[14:0] + 15'(i))] = sd[8*i +: 8];
    endtask

    task automatic check_wb(input exp_t w);
        chk("wb_reg_write", 64'(wb_reg_write), 64'(w.rw));
        chk("misalign", 64'(misalign), 64'(w.mis));
        if (w.care) begin
            chk("wb_rd", 64'(wb_rd), 64'(w.rd));
            chk("wb_write_data", wb_write_data, w.data);
            if (w.is_ld) chk("mem_out", mem_out, w.data);
        end
    endtask

    task automatic check_fwd(input exp_t e);
        chk("fwd_reg_write", 64'(mem_fwd_reg_write), 64'(e.fwd_rw));
        if (e.care) begin
            chk("fwd_rd", 64'(mem_fwd_rd), 64'(e.rd));
            chk("fwd_data", mem_fwd_data, e.res);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wb_reg_write"}, 64'(wb_reg_write), 64'd0);
        chk({tag, "_misalign"}, 64'(misalign), 64'd0);
        chk({tag, "_fwd_reg_write"}, 64'(mem_fwd_reg_write), 64'd0);
        chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_wb_write_data"}, wb_write_data, 64'd0);
        chk({tag, "_mem_out"}, mem_out, 64'd0);
        chk({tag, "_fwd_rd"}, 64'(mem_fwd_rd), 64'd0);
        chk({tag, "_fwd_data"}, mem_fwd_data, 64'd0);
    endtask

    // one instruction through EX; checks taps and the item reaching WB
    task automatic op(input bit rw, input bit mw, input bit mr,
                      input bit m2r, input bit fl, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] sd,
                      input logic [5:0] rd);
        exp_t e;
        bit   mis;
        int   n;
        n   = nbytes(f3);
        mis = (mw || mr) && ((int'(a[2:0]) % n) != 0);
        e.care   = !fl;
        e.is_ld  = !fl && m2r;
        e.rd     = rd;
        e.res    = a;
        e.fwd_rw = !fl && rw && (rd != 0);
        e.mis    = !fl && mis;
        e.rw     = !fl && rw && (rd != 0) && !mis;
        e.data   = a;
        if (!fl) begin
            if (mw && !mis) model_store(a, sd, n);
            if (m2r) e.data = mis ? 64'd0 : model_load(a, f3);
        end
        stall             = 1'b0;
        flush             = fl;
        in_reg_write      = rw;
        in_mem_write      = mw;
        in_mem_read       = mr;
        in_mem_to_reg     = m2r;
        in_funct3         = f3;
        in_alu_fpu_result = a;
        in_read_data2     = sd;
        in_rd             = rd;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_fwd(e);
        if (q.size() >= 2) begin
            last_wb = q.pop_front();
            check_wb(last_wb);
        end
    endtask

    task automatic nop();
        op(0, 0, 0, 0, 0, 3'b000, 64'd0, 64'd0, 6'd0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [63:0] a,
                      input logic [5:0] rd);
        op(1, 0, 1, 1, 0, f3, a, 64'd0, rd);
    endtask

    task automatic st(input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] sd);
        op(0, 1, 0, 0, 0, f3, a, sd, 6'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [7:0]  saved [8];
        int          k;

        bubble = '{default: '0};
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        in_reg_write = 1'b0;
        in_mem_write = 1'b0;
        in_mem_read = 1'b0;
        in_mem_to_reg = 1'b0;
        in_funct3 = '0;
        in_alu_fpu_result = '0;
        in_read_data2 = '0;
        in_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        st(3'b011, 64'h40, 64'h1122334455667788);
        ld(3'b011, 64'h40, 6'd5);
        ld(3'b000, 64'h47, 6'd1);
        ld(3'b100, 64'h47, 6'd2);
        st(3'b000, 64'h43, 64'h80);
        ld(3'b000, 64'h43, 6'd3);
        ld(3'b100, 64'h43, 6'd4);
        ld(3'b010, 64'h44, 6'd5);
        st(3'b010, 64'h42, 64'hDEADBEEF);
        ld(3'b011, 64'h40, 6'd6);
        op(1, 0, 0, 0, 0, 3'b000, 64'h123, 64'd0, 6'd0);
        op(1, 0, 0, 0, 0, 3'b000, 64'h123, 64'd0, 6'd7);
        nop();

        st(3'b011, 64'h48, 64'hCAFEBABE0BADF00D);
        stall = 1'b1;
        repeat (3) begin
            in_reg_write      = 1'b1;
            in_mem_write      = 1'b1;
            in_funct3         = 3'($urandom);
            in_alu_fpu_result = {$urandom, $urandom};
            in_read_data2     = {$urandom, $urandom};
            in_rd             = 6'($urandom);
            @(posedge clk);
            #1;
            check_wb(last_wb);
            check_fwd(q[q.size()-1]);
        end
        ld(3'b011, 64'h48, 6'd11);
        nop();

        op(1, 0, 0, 0, 0, 3'b000, 64'h999, 64'd0, 6'd9);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        check_wb(last_wb);
        q[q.size()-1] = bubble;
        check_fwd(bubble);
        op(1, 0, 0, 0, 1, 3'b000, 64'h777, 64'd0, 6'd10);
        nop();
        nop();

        ld(3'b011, 64'h40, 6'd6);
        op(1, 0, 0, 0, 0, 3'b000, 64'h55, 64'd0, 6'd12);
        for (int i = 0; i < 8; i++) saved[i] = mem_b[15'h40 + 15'(i)];
        st(3'b011, 64'h40, 64'h0F0E0D0C0B0A0908);
        rst = 1'b1;
        #2;
        check_zero("midrst");
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) mem_b[15'h40 + 15'(i)] = saved[i];
        ld(3'b011, 64'h40, 6'd13);
        nop();
        nop();

        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            a[14:0] = 15'h100 + 15'(8 * i);
            st(3'b011, a, {$urandom, $urandom});
        end
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            a = {$urandom, $urandom};
            a[14:0] = 15'h100 + 15'($urandom_range(0, 63));
            if (k <= 3)
                ld(3'($urandom_range(0, 7)), a, 6'($urandom));
            else if (k <= 6)
                st(3'($urandom_range(0, 3)), a, {$urandom, $urandom});
            else
                op(1, 0, 0, 0, (k == 9), 3'($urandom), a, 64'd0,
                   6'($urandom));
        end
        nop();
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
